draw_command_executor: RTL and testbench

- Consumer end of the 5-bit draw command stream produced by the screen sequencer.
- Decodes each new command into a screen rectangle and a colour source, then walks that rectangle pixel by pixel.
- Each pixel is issued as x/y/colour/plot to the 160x120, 3-bit-colour VGA adapter.
- Pure responder: no backpressure to the sequencer; reports busy/done/overrun status only.

---
 rtl/draw_cmd_pkg.sv | 32 +++
 rtl/draw_region_decode.sv | 65 ++++++
 rtl/draw_command_executor.sv | 101 ++++++++++
 tb/tb_draw_command_executor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_cmd_pkg.sv
// Shared draw command codes, screen geometry and palette for the screen sequencer
// and the draw command executor.
package draw_cmd_pkg;

  localparam int unsigned SCR_W    = 160;
  localparam int unsigned SCR_H    = 120;
  localparam int unsigned NOTE_Y0  = 56;
  localparam int unsigned SCORE_Y0 = 4;
  localparam int unsigned CLEAR_Y  = 60;

  localparam logic [4:0] CMD_BG0        = 5'h00;
  localparam logic [4:0] CMD_BG1        = 5'h01;
  localparam logic [4:0] CMD_NOTE_FIRST = 5'h02;
  localparam logic [4:0] CMD_NOTE_LAST  = 5'h10;
  localparam logic [4:0] CMD_SCORE0     = 5'h11;
  localparam logic [4:0] CMD_SCORE1     = 5'h12;
  localparam logic [4:0] CMD_BG2        = 5'h13;
  localparam logic [4:0] CMD_PLAY_CLEAR = 5'h14;
  localparam logic [4:0] CMD_FINE_L     = 5'h17;
  localparam logic [4:0] CMD_FINE_R     = 5'h18;
  localparam logic [4:0] CMD_PERFECT    = 5'h19;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] BLACK  = 3'b000;

  function automatic logic is_note_cmd(input logic [4:0] cmd);
    return (cmd >= CMD_NOTE_FIRST) && (cmd <= CMD_NOTE_LAST);
  endfunction

endpackage

// File: rtl/draw_region_decode.sv
// Combinational map from a draw command to its screen rectangle and colour source.
module draw_region_decode
  import draw_cmd_pkg::*;
(
  input  logic [4:0]  command,
  input  logic [3:0]  choose,
  input  logic [14:0] note_present,
  input  logic [2:0]  score_colour,
  output logic [7:0]  w,
  output logic [6:0]  h,
  output logic [7:0]  x0,
  output logic [6:0]  y0,
  output logic [2:0]  colour
);

  logic [3:0] slot;

  assign slot = 4'(command - CMD_NOTE_FIRST);

  always_comb begin
    w      = '0;
    h      = '0;
    x0     = '0;
    y0     = '0;
    colour = BLACK;
    case (command)
      CMD_BG0, CMD_BG1, CMD_BG2: begin
        w      = 8'(SCR_W);
        h      = 7'(SCR_H);
        colour = choose[3] ? WHITE : choose[2:0];
      end
      CMD_SCORE0, CMD_SCORE1: begin
        w      = 8'd15;
        h      = 7'd15;
        x0     = (command == CMD_SCORE0) ? 8'd4 : 8'd20;
        y0     = 7'(SCORE_Y0);
        colour = score_colour;
      end
      CMD_PLAY_CLEAR: begin
        w  = 8'(SCR_W);
        h  = 7'd1;
        y0 = 7'(CLEAR_Y);
      end
      CMD_FINE_L, CMD_FINE_R, CMD_PERFECT: begin
        w      = 8'd1;
        h      = 7'd32;
        y0     = 7'(NOTE_Y0 - 14);
        x0     = (command == CMD_FINE_L) ? 8'd16 :
                 (command == CMD_FINE_R) ? 8'd30 : 8'd23;
        colour = (command == CMD_PERFECT) ? WHITE : YELLOW;
      end
      default: begin
        // Codes outside the note range keep the zero-width default.
        if (is_note_cmd(command)) begin
          w      = 8'd8;
          h      = 7'd4;
          x0     = 8'd20 + {1'b0, slot, 3'b000};
          y0     = 7'(NOTE_Y0);
          colour = note_present[slot] ? RED : BLACK;
        end
      end
    endcase
  end

endmodule

// File: rtl/draw_command_executor.sv
// Walks the rectangle of each new draw command pixel by pixel into the VGA adapter.
// Build option: DRAW_EXEC_SKIP_BLACK_EN suppresses plots of black note-slot pixels.
module draw_command_executor
  import draw_cmd_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  command,
  input  logic [3:0]  choose,
  input  logic [14:0] note_present,
  input  logic [2:0]  score_colour,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;

  logic [1:0] state;
  logic [4:0] cmd_q;
  logic [7:0] xc;
  logic [6:0] yc;
  logic [7:0] w;
  logic [6:0] h;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [2:0] region_colour;
  logic       chg;
  logic       in_draw;
  logic       last_col;
  logic       last_pix;

  draw_region_decode u_decode (
    .command      (cmd_q),
    .choose       (choose),
    .note_present (note_present),
    .score_colour (score_colour),
    .w            (w),
    .h            (h),
    .x0           (x0),
    .y0           (y0),
    .colour       (region_colour)
  );

  assign chg      = (command != cmd_q);
  assign in_draw  = (state == S_DRAW);
  assign last_col = (xc == w - 8'd1);
  assign last_pix = last_col && (yc == h - 7'd1);

  assign busy   = (state == S_SETUP) || in_draw;
  assign done   = in_draw && last_pix;
  assign x      = in_draw ? x0 + xc : '0;
  assign y      = in_draw ? y0 + yc : '0;
  assign colour = in_draw ? region_colour : '0;

`ifdef DRAW_EXEC_SKIP_BLACK_EN
  assign plot = in_draw && !(is_note_cmd(cmd_q) && region_colour == BLACK);
`else
  assign plot = in_draw;
`endif

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= S_IDLE;
      cmd_q   <= 5'h1F;
      xc      <= '0;
      yc      <= '0;
      overrun <= 1'b0;
    end else if (chg) begin
      cmd_q <= command;
      state <= S_SETUP;
      // A change landing on the final pixel is not an overrun: that region completed.
      if (busy && !done) overrun <= 1'b1;
    end else begin
      case (state)
        S_SETUP: begin
          xc    <= '0;
          yc    <= '0;
          state <= (w == 8'd0) ? S_IDLE : S_DRAW;
        end
        S_DRAW: begin
          if (last_col) begin
            xc <= '0;
            yc <= yc + 7'd1;
          end else begin
            xc <= xc + 8'd1;
          end
          if (last_pix) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_command_executor.sv
// Directed self-checking bench for draw_command_executor; honours DRAW_EXEC_SKIP_BLACK_EN.
module tb_draw_command_executor;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  command;
  logic [3:0]  choose;
  logic [14:0] note_present;
  logic [2:0]  score_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done, overrun;
  logic [20:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // {plot, done, busy, x, y, colour}
  assign obs = {plot, done, busy, x, y, colour};

  draw_command_executor dut (
    .CLK          (CLK),
    .reset        (reset),
    .command      (command),
    .choose       (choose),
    .note_present (note_present),
    .score_colour (score_colour),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  localparam logic [20:0] IDLE_V  = 21'd0;
  localparam logic [20:0] SETUP_V = {3'b001, 18'd0};

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    reset = 1'b0; command = 5'h1F; choose = '0; note_present = '0; score_colour = '0;
    repeat (3) tick;
    checks++;
    if (obs !== IDLE_V || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h ovr %b, want %h ovr 0", obs, overrun, IDLE_V);
    end
    reset = 1'b1;
    tick; tick;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_release_idle: got %h, want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_note_slot;
    logic [20:0] exp;
    note_present = 15'h0001;
    command = 5'h02;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL note_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 32; k++) begin
      tick;
      exp = {1'b1, k == 31, 1'b1, 8'(20 + k % 8), 7'(56 + k / 8), 3'b100};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL note_px%0d: got %h, want %h", k, obs, exp); end
    end
    tick;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL note_idle: got %h, want %h", obs, IDLE_V); end
  endtask

  task automatic test_full_screen;
    logic [20:0] exp;
    choose = 4'd3;
    command = 5'h13;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL bg_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 19200; k++) begin
      tick;
      exp = {1'b1, k == 19199, 1'b1, 8'(k % 160), 7'(k / 160), 3'b011};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bg_px%0d: got %h, want %h", k, obs, exp); end
    end
    tick;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL bg_idle: got %h, want %h", obs, IDLE_V); end
  endtask

  task automatic test_empty_region;
    logic [20:0] exp;
    command = 5'h14;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL clear_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 160; k++) begin
      tick;
      exp = {1'b1, k == 159, 1'b1, 8'(k), 7'd60, 3'b000};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL clear_px%0d: got %h, want %h", k, obs, exp); end
    end
    tick;
    command = 5'h15;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL empty_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (obs !== IDLE_V) begin errors++; $display("FAIL empty_idle%0d: got %h, want %h", k, obs, IDLE_V); end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL empty_overrun: got %b, want 0", overrun); end
  endtask

  task automatic test_overrun;
    logic [20:0] exp;
    score_colour = 3'b101;
    command = 5'h11;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL score0_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 100; k++) begin
      tick;
      exp = {1'b1, 1'b0, 1'b1, 8'(4 + k % 15), 7'(4 + k / 15), 3'b101};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL score0_px%0d: got %h, want %h", k, obs, exp); end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL pre_overrun: got %b, want 0", overrun); end
    command = 5'h12;
    tick;
    checks++;
    if (obs !== SETUP_V || overrun !== 1'b1) begin
      errors++;
      $display("FAIL score1_setup: got %h ovr %b, want %h ovr 1", obs, overrun, SETUP_V);
    end
    for (int k = 0; k < 225; k++) begin
      tick;
      exp = {1'b1, k == 224, 1'b1, 8'(20 + k % 15), 7'(4 + k / 15), 3'b101};
      checks++;
      if (obs !== exp || overrun !== 1'b1) begin
        errors++;
        $display("FAIL score1_px%0d: got %h ovr %b, want %h ovr 1", k, obs, overrun, exp);
      end
    end
    tick;
    checks++;
    if (obs !== IDLE_V || overrun !== 1'b1) begin
      errors++;
      $display("FAIL score1_idle: got %h ovr %b, want %h ovr 1", obs, overrun, IDLE_V);
    end
  endtask

  task automatic test_empty_slot;
    logic [20:0] exp;
    logic        plot_exp;
`ifdef DRAW_EXEC_SKIP_BLACK_EN
    plot_exp = 1'b0;
`else
    plot_exp = 1'b1;
`endif
    note_present = '0;
    command = 5'h05;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL slot3_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 32; k++) begin
      tick;
      exp = {plot_exp, k == 31, 1'b1, 8'(44 + k % 8), 7'(56 + k / 8), 3'b000};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL slot3_px%0d: got %h, want %h", k, obs, exp); end
    end
    tick;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL slot3_idle: got %h, want %h", obs, IDLE_V); end
  endtask

  task automatic test_reset_mid_draw;
    logic [20:0] exp;
    choose = 4'd9;
    command = 5'h00;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL bg0_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 50; k++) begin
      tick;
      exp = {1'b1, 1'b0, 1'b1, 8'(k), 7'd0, 3'b111};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bg0_px%0d: got %h, want %h", k, obs, exp); end
    end
    reset = 1'b0;
    tick;
    checks++;
    if (obs !== IDLE_V || overrun !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got %h ovr %b, want %h ovr 0", obs, overrun, IDLE_V);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (obs !== SETUP_V) begin errors++; $display("FAIL restart_setup: got %h, want %h", obs, SETUP_V); end
    for (int k = 0; k < 3; k++) begin
      tick;
      exp = {1'b1, 1'b0, 1'b1, 8'(k), 7'd0, 3'b111};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL restart_px%0d: got %h, want %h", k, obs, exp); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_note_slot;
    test_full_screen;
    test_empty_region;
    test_overrun;
    test_empty_slot;
    test_reset_mid_draw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
